// File: rtl/aes_pkg.sv
// Shared AES constants and the SubBytes engine FSM state encoding.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t IDLE = 2'd0;
    localparam fsm_state_t SUB  = 2'd1;
    localparam fsm_state_t DONE = 2'd2;

endpackage

// File: rtl/sbox_lookup.sv
// Combinational FIPS-197 forward S-box: one byte in, one substituted byte out.
module sbox_lookup (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Row-major table: entry for value v sits at bits [(255-v)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bitBase;

    assign bitBase = {3'b000, ~data_i} << 3;
    assign data_o  = SBOX_TABLE[bitBase +: 8];

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: substitutes BYTES_PER_CYCLE bytes of a captured
// 128-bit state per cycle in place, then holds the result until consumed.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_GROUPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int GROUP_W    = BYTES_PER_CYCLE * AES_BYTE_W;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

    fsm_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           groupCnt_q, groupCnt_d;
    logic [AES_STATE_W-1:0]     workState_q, workState_d;
    logic [GROUP_W-1:0]         groupIn;
    logic [GROUP_W-1:0]         groupOut;

    // Group g covers bytes g*BPC.., with byte 0 in the most significant position.
    always_comb begin
        groupIn = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (groupCnt_q == CNT_W'(g)) begin
                groupIn = workState_q[AES_STATE_W-1-g*GROUP_W -: GROUP_W];
            end
        end
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        sbox_lookup u_sbox (
            .data_i(groupIn[GROUP_W-1-b*AES_BYTE_W -: AES_BYTE_W]),
            .data_o(groupOut[GROUP_W-1-b*AES_BYTE_W -: AES_BYTE_W])
        );
    end

    always_comb begin
        state_d     = state_q;
        groupCnt_d  = groupCnt_q;
        workState_d = workState_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    workState_d = in_state;
                    groupCnt_d  = '0;
                    state_d     = SUB;
                end
            end
            SUB: begin
                for (int g = 0; g < NUM_GROUPS; g++) begin
                    if (groupCnt_q == CNT_W'(g)) begin
                        workState_d[AES_STATE_W-1-g*GROUP_W -: GROUP_W] = groupOut;
                    end
                end
                if (groupCnt_q == LAST_GROUP) begin
                    groupCnt_d = '0;
                    state_d    = DONE;
                end else begin
                    groupCnt_d = groupCnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            groupCnt_q  <= '0;
            workState_q <= '0;
        end else begin
            state_q     <= state_d;
            groupCnt_q  <= groupCnt_d;
            workState_q <= workState_d;
        end
    end

    // in_ready is held low while reset is asserted so no block is offered early.
    assign in_ready  = (state_q == IDLE) && reset_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = workState_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine at BYTES_PER_CYCLE = 4, 1 and 16,
// with a reference S-box derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   inValid, inReady, outValid, outReady, busy;
    logic [127:0] inState  [3];
    logic [127:0] outState [3];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [7:0] sboxRef [256];
    logic [7:0] perm    [256];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    sub_bytes_engine #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_state(inState[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_state(outState[0]),
        .busy(busy[0])
    );

    sub_bytes_engine #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_state(inState[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_state(outState[1]),
        .busy(busy[1])
    );

    sub_bytes_engine #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_state(inState[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_state(outState[2]),
        .busy(busy[2])
    );

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] subState(logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sboxRef[s[127-8*i -: 8]];
        end
        return r;
    endfunction

    task automatic buildModel();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sboxRef[v] = affine(inv);
        end
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j       = int'($urandom_range(i, 0));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one block, waits for acceptance, then counts edges until out_valid.
    task automatic applyStimulus(input int idx, input logic [127:0] data,
                                 output int lat, output int acceptCyc);
        int w = 0;
        inValid[idx] = 1'b1;
        inState[idx] = data;
        while (!inReady[idx] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput($sformatf("accept_ready_%0d", idx), 128'(inReady[idx]), 128'd1);
        @(posedge clk); #1;
        acceptCyc    = cycle;
        inValid[idx] = 1'b0;
        lat = 0;
        while (!outValid[idx] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput($sformatf("out_valid_%0d", idx), 128'(outValid[idx]), 128'd1);
    endtask

    task automatic runBurst(input int idx, input int nBlocks, input int k, input bit usePerm);
        int lat, acc, prevAcc;
        logic [127:0] d;
        prevAcc = 0;
        outReady[idx] = 1'b1;
        for (int b = 0; b < nBlocks; b++) begin
            for (int j = 0; j < 16; j++) begin
                d[127-8*j -: 8] = usePerm ? perm[16*b+j] : 8'($urandom);
            end
            applyStimulus(idx, d, lat, acc);
            checkOutput($sformatf("burst%0d_state_b%0d", idx, b), outState[idx], subState(d));
            checkOutput($sformatf("burst%0d_lat_b%0d", idx, b), 128'(lat), 128'(k));
            if (b > 0) begin
                checkOutput($sformatf("burst%0d_period_b%0d", idx, b), 128'(acc - prevAcc), 128'(k + 2));
            end
            prevAcc = acc;
        end
        @(posedge clk); #1;
        checkOutput($sformatf("burst%0d_idle", idx), 128'(busy[idx]), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, acc;
        bit sawValid;
        logic [127:0] d, expd;

        reset_n  = 1'b0;
        inValid  = '0;
        outReady = '0;
        for (int i = 0; i < 3; i++) inState[i] = '0;
        buildModel();

        #2;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_out_valid_%0d", i), 128'(outValid[i]), 128'd0);
            checkOutput($sformatf("rst_busy_%0d", i), 128'(busy[i]), 128'd0);
            checkOutput($sformatf("rst_in_ready_%0d", i), 128'(inReady[i]), 128'd0);
            checkOutput($sformatf("rst_out_state_%0d", i), outState[i], 128'd0);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("post_rst_in_ready_%0d", i), 128'(inReady[i]), 128'd1);
        end
        @(posedge clk); #1;

        // FIPS-197 round-1 SubBytes vector.
        outReady[0] = 1'b1;
        applyStimulus(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, lat, acc);
        checkOutput("s1_state", outState[0], 128'hd42711aee0bf98f1b8b45de51e415230);
        checkOutput("s1_latency", 128'(lat), 128'd4);
        @(posedge clk); #1;
        checkOutput("s1_handshake_valid", 128'(outValid[0]), 128'd0);
        checkOutput("s1_handshake_busy", 128'(busy[0]), 128'd0);

        d = {4{32'h0053ff01}};
        applyStimulus(0, d, lat, acc);
        checkOutput("s2_state_const", outState[0], {4{32'h63ed167c}});
        checkOutput("s2_state_model", outState[0], subState(d));
        @(posedge clk); #1;

        // Backpressure: result must hold and new offers must be ignored.
        outReady[0] = 1'b0;
        d    = {$urandom, $urandom, $urandom, $urandom};
        expd = subState(d);
        applyStimulus(0, d, lat, acc);
        checkOutput("s3_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            inValid[0] = i[0];
            inState[0] = {$urandom, $urandom, $urandom, $urandom};
            checkOutput($sformatf("s3_valid_c%0d", i), 128'(outValid[0]), 128'd1);
            checkOutput($sformatf("s3_state_c%0d", i), outState[0], expd);
            checkOutput($sformatf("s3_in_ready_c%0d", i), 128'(inReady[0]), 128'd0);
            @(posedge clk); #1;
        end
        inValid[0] = 1'b0;
        checkOutput("s3_state_after", outState[0], expd);
        outReady[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("s3_release_valid", 128'(outValid[0]), 128'd0);
        checkOutput("s3_release_busy", 128'(busy[0]), 128'd0);

        // Reset during the second SUB cycle.
        inValid[0] = 1'b1;
        inState[0] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        inValid[0] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("s4_rst_valid", 128'(outValid[0]), 128'd0);
        checkOutput("s4_rst_busy", 128'(busy[0]), 128'd0);
        checkOutput("s4_rst_in_ready", 128'(inReady[0]), 128'd0);
        checkOutput("s4_rst_state", outState[0], 128'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        checkOutput("s4_in_ready_after", 128'(inReady[0]), 128'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sawValid = sawValid | outValid[0];
        end
        checkOutput("s4_no_partial", 128'(sawValid), 128'd0);
        d = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, d, lat, acc);
        checkOutput("s4_next_state", outState[0], subState(d));
        checkOutput("s4_next_latency", 128'(lat), 128'd4);
        @(posedge clk); #1;

        // Parameter sweep with an all-zero state.
        outReady[1] = 1'b1;
        applyStimulus(1, 128'd0, lat, acc);
        checkOutput("s5_bpc1_state", outState[1], {16{8'h63}});
        checkOutput("s5_bpc1_latency", 128'(lat), 128'd16);
        @(posedge clk); #1;
        outReady[2] = 1'b1;
        applyStimulus(2, 128'd0, lat, acc);
        checkOutput("s5_bpc16_state", outState[2], {16{8'h63}});
        checkOutput("s5_bpc16_latency", 128'(lat), 128'd1);
        @(posedge clk); #1;

        // All 256 byte values over 16 back-to-back blocks, plus random bursts.
        runBurst(0, 16, 4, 1'b1);
        runBurst(1, 2, 16, 1'b0);
        runBurst(2, 4, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
